// File: rtl/i2c_reg_writer_if.sv
// i2c_reg_writer_if: request/status handshake toward the codec-configuration
// controller plus the command/ready/SDA link toward bit_stream, bundled so the
// sequencer takes a single bus port.
//   slave  : the sequencer side (i2c_reg_writer)
//   master : the environment side (controller + bit_stream, or a testbench)
interface i2c_reg_writer_if;
  logic        start;
  logic [6:0]  dev_addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        nack;
  logic [2:0]  command;
  logic        ready;
  logic        sda_in;

  modport slave (
    input  start, dev_addr, wdata, ready, sda_in,
    output busy, done, nack, command
  );

  modport master (
    output start, dev_addr, wdata, ready, sda_in,
    input  busy, done, nack, command
  );
endinterface

// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer: expands one register-write request (7-bit device address,
// 16-bit payload) into the 29-step I2C sequence START, addr+W, ACK, high byte,
// ACK, low byte, ACK, STOP, issuing one bit_stream command per step and
// handshaking on ready. ACK slots are sampled from SDA mid-bit.
//
// Build option: define I2C_ACK_ABORT_EN to jump straight to STOP after the
// first ACK slot that reads high. Without it all 29 steps always run and the
// NACK is only reported at done.
module i2c_reg_writer #(
  parameter int CYCLESPERBIT = 500
) (
  input  logic           clk,
  input  logic           reset,
  i2c_reg_writer_if.slave bus
);

  // bit_stream command codes
  localparam logic [2:0] CMDWAIT  = 3'd0;
  localparam logic [2:0] CMDSTART = 3'd1;
  localparam logic [2:0] CMDSTOP  = 3'd2;
  localparam logic [2:0] CMDBIT0  = 3'd3;
  localparam logic [2:0] CMDBIT1  = 3'd4;
  localparam logic [2:0] CMDRBIT  = 3'd5;

  localparam logic [4:0]  STEP_LAST = 5'd28;
  localparam logic [11:0] TIMER_MAX = 12'hFFF;
  // ACK is read in the middle of the SCK-high window
  localparam logic [11:0] SAMPLE_AT = 12'(CYCLESPERBIT / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAITRDY = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  step_r, step_s;
  logic [11:0] timer_r, timer_s;
  logic [6:0]  addr_r, addr_s;
  logic [15:0] data_r, data_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        nack_r, nack_s;
  logic [2:0]  command_r, command_s;
  logic [4:0]  step_next_s;

  // Map a step index onto its bit_stream command. The 24 data bits form the
  // frame {addr, R/W=0, wdata}, sent MSB first with an ACK slot after each byte.
  function automatic logic [2:0] step_command(input logic [4:0]  step,
                                              input logic [6:0]  addr,
                                              input logic [15:0] data);
    logic [23:0] frame;
    logic [4:0]  idx;
    logic [2:0]  cmd;
    frame = {addr, 1'b0, data};
    idx   = 5'd0;
    cmd   = CMDWAIT;
    if (step == 5'd0) begin
      cmd = CMDSTART;
    end else if (step <= 5'd8) begin
      idx = 5'd24 - step;
      cmd = frame[idx] ? CMDBIT1 : CMDBIT0;
    end else if (step == 5'd9) begin
      cmd = CMDRBIT;
    end else if (step <= 5'd17) begin
      idx = 5'd25 - step;
      cmd = frame[idx] ? CMDBIT1 : CMDBIT0;
    end else if (step == 5'd18) begin
      cmd = CMDRBIT;
    end else if (step <= 5'd26) begin
      idx = 5'd26 - step;
      cmd = frame[idx] ? CMDBIT1 : CMDBIT0;
    end else if (step == 5'd27) begin
      cmd = CMDRBIT;
    end else if (step == STEP_LAST) begin
      cmd = CMDSTOP;
    end else begin
      cmd = CMDWAIT;
    end
    return cmd;
  endfunction

  // Choose the step that follows the current one (optionally cutting to STOP on NACK).
  always_comb begin
    step_next_s = step_r + 5'd1;
`ifdef I2C_ACK_ABORT_EN
    if (nack_r && ((step_r == 5'd9) || (step_r == 5'd18) || (step_r == 5'd27))) begin
      step_next_s = STEP_LAST;
    end else begin
      step_next_s = step_r + 5'd1;
    end
`else
    step_next_s = step_r + 5'd1;
`endif
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    timer_s   = timer_r;
    addr_s    = addr_r;
    data_s    = data_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    nack_s    = nack_r;
    command_s = command_r;
    case (state_r)
      IDLE: begin
        command_s = CMDWAIT;
        if (bus.start) begin
          addr_s  = bus.dev_addr;
          data_s  = bus.wdata;
          nack_s  = 1'b0;
          step_s  = 5'd0;
          busy_s  = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        command_s = step_command(step_r, addr_r, data_r);
        timer_s   = 12'd0;
        state_s   = WAITRDY;
      end
      WAITRDY: begin
        if (timer_r != TIMER_MAX) begin
          timer_s = timer_r + 12'd1;
        end else begin
          timer_s = timer_r;
        end
        if ((command_r == CMDRBIT) && (timer_r == SAMPLE_AT) && bus.sda_in) begin
          nack_s = 1'b1;
        end else begin
          nack_s = nack_r;
        end
        // command drops to WAIT as the FSM enters RELEASE, never earlier
        if (bus.ready) begin
          command_s = CMDWAIT;
          state_s   = RELEASE;
        end else begin
          state_s   = WAITRDY;
        end
      end
      RELEASE: begin
        command_s = CMDWAIT;
        if (!bus.ready) begin
          if (step_r == STEP_LAST) begin
            state_s = DONE;
          end else begin
            step_s  = step_next_s;
            state_s = ISSUE;
          end
        end else begin
          state_s = RELEASE;
        end
      end
      DONE: begin
        command_s = CMDWAIT;
        done_s    = 1'b1;
        busy_s    = 1'b0;
        step_s    = 5'd0;
        state_s   = IDLE;
      end
      default: begin
        command_s = CMDWAIT;
        busy_s    = 1'b0;
        step_s    = 5'd0;
        state_s   = IDLE;
      end
    endcase
  end

  // State register plus captured request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      step_r    <= 5'd0;
      timer_r   <= 12'd0;
      addr_r    <= 7'd0;
      data_r    <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      nack_r    <= 1'b0;
      command_r <= CMDWAIT;
    end else begin
      state_r   <= state_s;
      step_r    <= step_s;
      timer_r   <= timer_s;
      addr_r    <= addr_s;
      data_r    <= data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      nack_r    <= nack_s;
      command_r <= command_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.nack    = nack_r;
  assign bus.command = command_r;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// tb_i2c_reg_writer: drives i2c_reg_writer against a behavioural bit_stream
// stand-in (ready after CYCLESPERBIT+2 command cycles, drops one cycle after
// WAIT, drives ACK levels during read bits) and compares the logged command
// stream, NACK status and done latency with a byte-level reference model.
module tb_i2c_reg_writer;
  localparam int CPB      = 40;
  localparam int STEP_CYC = CPB + 6;
  localparam logic [2:0] C_WAIT = 3'd0, C_START = 3'd1, C_STOP = 3'd2,
                         C_BIT0 = 3'd3, C_BIT1  = 3'd4, C_RBIT = 3'd5;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #10 clk = ~clk;

  // Free-running cycle count for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  i2c_reg_writer_if bus();
  i2c_reg_writer #(.CYCLESPERBIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus));

  // bit_stream stand-in state
  logic       rdy;
  int         cnt;
  int         extra;
  logic       sda_lvl;
  logic [2:0] prev_cmd;
  logic [2:0] log_q[$];
  int         base_idx = 0;
  int         stall_rel = -1;
  logic [2:0] pat = 3'b000;

  assign bus.ready  = rdy;
  assign bus.sda_in = (bus.command == C_RBIT) ? sda_lvl : 1'b1;

  function automatic int rbits_since(input int b);
    int n = 0;
    for (int i = b; i < log_q.size(); i++) if (log_q[i] == C_RBIT) n++;
    return n;
  endfunction

  // Log each new command, time its ready response and set the ACK level.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy <= 1'b0; cnt <= 0; extra <= 0; sda_lvl <= 1'b1; prev_cmd <= C_WAIT;
    end else begin
      prev_cmd <= bus.command;
      if (bus.command != C_WAIT && prev_cmd == C_WAIT) begin
        extra <= (stall_rel >= 0 && log_q.size() == base_idx + stall_rel) ? 10 : 0;
        if (bus.command == C_RBIT) begin
          int k;
          k = rbits_since(base_idx);
          sda_lvl <= (k < 3) ? pat[2'(k)] : 1'b1;
        end else begin
          sda_lvl <= 1'b1;
        end
        log_q.push_back(bus.command);
      end
      if (bus.command == C_WAIT) begin
        rdy <= 1'b0; cnt <= 0;
      end else if (!rdy) begin
        cnt <= cnt + 1;
        if (cnt + 1 >= CPB + 2 + extra) rdy <= 1'b1;
      end
    end
  end

  // Reference model: whole bytes, MSB first, ACK after each, STOP at the end.
  logic [2:0] exp_q[$];
  logic       exp_nack;
  int         exp_steps;

  function automatic void build_model(input logic [6:0] a, input logic [15:0] d,
                                      input logic [2:0] p);
    logic [7:0] bytes [3];
    bytes[0] = {a, 1'b0}; bytes[1] = d[15:8]; bytes[2] = d[7:0];
    exp_q.delete();
    exp_nack = 1'b0;
    exp_q.push_back(C_START);
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(bytes[b][i] ? C_BIT1 : C_BIT0);
      exp_q.push_back(C_RBIT);
      if (p[b]) begin
        exp_nack = 1'b1;
`ifdef I2C_ACK_ABORT_EN
        break;
`endif
      end
    end
    exp_q.push_back(C_STOP);
    exp_steps = exp_q.size();
  endfunction

  function automatic int log_errs(input int b);
    int e = 0;
    if (log_q.size() - b != exp_q.size()) e++;
    for (int i = 0; i < exp_q.size(); i++)
      if (b + i >= log_q.size() || log_q[b + i] != exp_q[i]) e++;
    return e;
  endfunction

  task automatic start_req(input logic [6:0] a, input logic [15:0] d);
    bus.dev_addr = a; bus.wdata = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic launch(input logic [6:0] a, input logic [15:0] d, input logic [2:0] p,
                        input int stall, output int s);
    pat = p; stall_rel = stall; base_idx = log_q.size();
    build_model(a, d, p);
    s = cyc;
    start_req(a, d);
  endtask

  task automatic wait_done(input int s, output int took, output bit to);
    to = 1'b0;
    while (bus.done !== 1'b1) begin
      if (cyc - s > 4000) begin to = 1'b1; break; end
      @(posedge clk); #1;
    end
    took = cyc - s;
  endtask

  task automatic wait_log(input int n, output bit ok);
    int k = 0;
    while (log_q.size() < base_idx + n && k < 3000) begin @(posedge clk); #1; k++; end
    ok = (log_q.size() >= base_idx + n);
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.dev_addr = 7'd0; bus.wdata = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests_run++; if (bus.nack !== 1'b0) begin tests_failed++; $display("FAIL reset_nack got %b want 0", bus.nack); end
    tests_run++; if (bus.command !== C_WAIT) begin tests_failed++; $display("FAIL reset_cmd got %0d want %0d", bus.command, C_WAIT); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int s, took, e; bit to;
    launch(7'h1A, 16'h0C00, 3'b000, -1, s);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL busy_rise got %b want 1", bus.busy); end
    tests_run++; if (bus.command !== C_WAIT) begin tests_failed++; $display("FAIL cmd_start_early got %0d want %0d", bus.command, C_WAIT); end
    @(posedge clk); #1;
    tests_run++; if (bus.command !== C_START) begin tests_failed++; $display("FAIL cmd_start got %0d want %0d", bus.command, C_START); end
    wait_done(s, took, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL nominal_timeout got busy %b want done", bus.busy); end
    tests_run++; if (took < exp_steps*STEP_CYC || took > exp_steps*STEP_CYC + 4) begin tests_failed++; $display("FAIL nominal_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL busy_at_done got %b want 0", bus.busy); end
    tests_run++; if (bus.nack !== 1'b0) begin tests_failed++; $display("FAIL nominal_nack got %b want 0", bus.nack); end
    e = log_errs(base_idx);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL nominal_cmds got %0d mismatches want 0", e); end
    @(posedge clk); #1;
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_nack18();
    int s, took, e; bit to;
    launch(7'h1A, 16'h0C00, 3'b010, -1, s);
    wait_done(s, took, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL nack18_timeout got busy %b want done", bus.busy); end
    tests_run++; if (bus.nack !== 1'b1) begin tests_failed++; $display("FAIL nack18_nack got %b want 1", bus.nack); end
    tests_run++; if (took != exp_steps*STEP_CYC + 2) begin tests_failed++; $display("FAIL nack18_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
    e = log_errs(base_idx);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL nack18_cmds got %0d mismatches want 0", e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int s, took, e; bit to;
    logic [6:0] a; logic [15:0] d; logic [2:0] p;
    for (int n = 0; n < 4; n++) begin
      a = 7'($urandom); d = 16'($urandom);
      p = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      launch(a, d, p, -1, s);
      tests_run++; if (bus.nack !== 1'b0) begin tests_failed++; $display("FAIL rnd_nack_clear got %b want 0", bus.nack); end
      wait_done(s, took, to);
      tests_run++; if (to || took != exp_steps*STEP_CYC + 2) begin tests_failed++; $display("FAIL rnd_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
      tests_run++; if (bus.nack !== exp_nack) begin tests_failed++; $display("FAIL rnd_nack got %b want %b", bus.nack, exp_nack); end
      e = log_errs(base_idx);
      tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL rnd_cmds got %0d mismatches want 0", e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int s, took, e; bit to, ok;
    launch(7'h1A, 16'h0C00, 3'b000, -1, s);
    wait_log(6, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ign_reach_step5 got %0d cmds want 6", log_q.size() - base_idx); end
    bus.dev_addr = 7'h7F; bus.wdata = 16'hFFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL ign_busy got %b want 1", bus.busy); end
    wait_done(s, took, to);
    tests_run++; if (to || took != exp_steps*STEP_CYC + 2) begin tests_failed++; $display("FAIL ign_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
    e = log_errs(base_idx);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL ign_payload got %0d mismatches want 0", e); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int s, took, e; bit to;
    launch(7'($urandom), 16'($urandom), 3'b000, 3, s);
    wait_done(s, took, to);
    tests_run++; if (to || took != exp_steps*STEP_CYC + 12) begin tests_failed++; $display("FAIL stall_latency got %0d want %0d", took, exp_steps*STEP_CYC + 12); end
    e = log_errs(base_idx);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL stall_cmds got %0d mismatches want 0", e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s, took, e, b2; bit to;
    launch(7'($urandom), 16'hA55A, 3'b000, -1, s);
    wait_done(s, took, to);
    tests_run++; if (to || took != exp_steps*STEP_CYC + 2) begin tests_failed++; $display("FAIL b2b_first_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
    e = log_errs(base_idx);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL b2b_first_cmds got %0d mismatches want 0", e); end
    @(posedge clk); #1;
    b2 = log_q.size();
    launch(7'($urandom), 16'($urandom), 3'b000, -1, s);
    wait_done(s, took, to);
    tests_run++; if (to || took != exp_steps*STEP_CYC + 2) begin tests_failed++; $display("FAIL b2b_second_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
    e = log_errs(b2);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL b2b_second_cmds got %0d mismatches want 0", e); end
    tests_run++; if (b2 < 1 || log_q[b2 - 1] !== C_STOP) begin tests_failed++; $display("FAIL b2b_order got %0d want %0d before second START", (b2 < 1) ? 0 : log_q[b2 - 1], C_STOP); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int s, took, e; bit to, ok;
    launch(7'($urandom), 16'($urandom), 3'b000, -1, s);
    wait_log(13, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL mr_reach_step12 got %0d cmds want 13", log_q.size() - base_idx); end
    reset = 1'b0;
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mr_busy got %b want 0", bus.busy); end
    tests_run++; if (bus.command !== C_WAIT) begin tests_failed++; $display("FAIL mr_cmd got %0d want %0d", bus.command, C_WAIT); end
    @(posedge clk); #1;
    tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL mr_hold got busy %b done %b want 0 0", bus.busy, bus.done); end
    reset = 1'b1;
    @(posedge clk); #1;
    launch(7'($urandom), 16'($urandom), 3'b000, -1, s);
    wait_done(s, took, to);
    tests_run++; if (to || took != exp_steps*STEP_CYC + 2) begin tests_failed++; $display("FAIL mr_after_latency got %0d want %0d", took, exp_steps*STEP_CYC + 2); end
    e = log_errs(base_idx);
    tests_run++; if (e !== 0) begin tests_failed++; $display("FAIL mr_after_cmds got %0d mismatches want 0", e); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_nack18();
    test_random();
    test_ignore_start();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_reg_writer.md
# i2c_reg_writer

Transaction sequencer directly upstream of `bit_stream` in the sinewave-generator I2C path. It accepts a single-cycle write request (7-bit device address plus 16-bit payload) and expands it into the full I2C bit sequence: START, address+W, ACK, high byte, ACK, low byte, ACK, STOP. It issues one `bit_stream` command per step, handshakes on `ready`, samples the slave ACK from the bus, and reports completion and NACK status to the codec-configuration controller above it.

## Interface
- `CYCLESPERBIT`, 500, clock cycles per I2C bit; must equal the `bit_stream` instance value.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `dev_addr`  in  7  slave address; captured on an accepted `start`.
- `wdata`  in  16  payload, sent MSB first; captured on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `nack`  out  1  high if any ACK slot read 1; cleared on the next accepted `start`.
- `command`  out  3  command to `bit_stream`, using the `bit_stream.h` codes.
- `ready`  in  1  `bit_stream` ready.
- `sda_in`  in  1  bus SDA level, used for ACK sampling.

## Operation
- Step index `step` (5-bit) runs 0..28:
  - 0 = CMDSTART.
  - 1..8 = address bits a6..a0, then R/W=0, each sent as CMDBIT0 or CMDBIT1.
  - 9 = CMDRBIT (ACK).
  - 10..17 = wdata[15:8].
  - 18 = CMDRBIT.
  - 19..26 = wdata[7:0].
  - 27 = CMDRBIT.
  - 28 = CMDSTOP.
- FSM states: IDLE, ISSUE, WAITRDY, RELEASE, DONE.
  - IDLE: `command`=CMDWAIT. On `start`, latch `dev_addr`/`wdata`, clear `nack`, set `step`=0, go to ISSUE.
  - ISSUE: drive the step's command, clear the bit timer, go to WAITRDY.
  - WAITRDY: hold the step's command and increment the bit timer. For a CMDRBIT step, sample `sda_in` when timer == CYCLESPERBIT/2 (SCK-high window); a sampled value of 1 sets `nack`. When `ready`=1, go to RELEASE.
  - RELEASE: `command`=CMDWAIT. When `ready`=0: if `step`=28, go to DONE; otherwise advance `step` and go to ISSUE.
  - DONE: assert `done` for one cycle, `command`=CMDWAIT, return to IDLE.
- A `start` while `busy`=1 is ignored; the latched data does not change.
- Bit timer is 12-bit and saturates at 4095.

## Timing
- Reset values: `busy`=0, `done`=0, `nack`=0, `command`=CMDWAIT; FSM in IDLE with `step`=0. The timer and latched registers reset to 0.
- Reset applied mid-transaction: all outputs take their reset values immediately. The bus is left to `bit_stream`'s own reset.
- `busy` rises one cycle after the accepted `start`. The first CMDSTART appears on `command` two cycles after `start`.
- Per step: 1 ISSUE cycle, CYCLESPERBIT+3 cycles until `ready`, and 2 cycles RELEASE (ready drops one cycle after CMDWAIT).
  - Nominal per step: CYCLESPERBIT+6 cycles.
  - Nominal transaction: 29·(CYCLESPERBIT+6)+2 cycles from `start` to `done`.
- `done` and `busy` fall in the same cycle. A new `start` is accepted in the cycle after `done`.
- `command` changes only in ISSUE and RELEASE. It is never CMDWAIT while `bit_stream` is in PRE/BIT/POST.

## Configuration
- `I2C_ACK_ABORT_EN` defined:
  - A NACK sampled at step 9, 18 or 27 makes the next step 28 (STOP). Remaining bits are skipped.
  - `done` follows the STOP with `nack`=1.
- `I2C_ACK_ABORT_EN` undefined:
  - All 29 steps always execute.
  - `nack` is reported at `done`.

## Test plan
- Reset with `reset`=0 mid-step 12 → `busy`=0, `command`=CMDWAIT on the next edge. After release, a fresh `start` completes normally.
- `dev_addr`=7'h1A, `wdata`=16'h0C00, slave ACKs all → SDA bit order matches 0x34, 0x0C, 0x00 framed by START/STOP. `done`=1 and `nack`=0 at 29·506+2 cycles ±2.
- Same request, SDA held high at step 18:
  - With `I2C_ACK_ABORT_EN`: STOP issued immediately after step 18, `done` with `nack`=1.
  - Without it: 29 steps, `nack`=1.
- `start` pulsed again at step 5 with `wdata`=16'hFFFF → ignored. The transmitted payload remains 16'h0C00.
- `wdata`=16'hA55A back-to-back with a second request the cycle after `done` → both transactions complete. The second one's START follows the first one's STOP with no overlap.
- `ready` stalled low for 10 extra cycles in step 3 → FSM holds the command in WAITRDY, with no step skipped and no duplicate command.
